usb_phy_tx: RTL and testbench

- Full/low-speed USB 1.1 transmit PHY stage, directly downstream of the host SIE's UTMI TX interface.
- Accepts bytes on the UTMI txvalid/txready handshake and adds SYNC, bit stuffing and NRZI encoding.
- Generates EOP and drives the D+/D- pads plus output enable.
- Running at 48 MHz, it serialises at 12 Mb/s (FS) or 1.5 Mb/s (LS), selected per packet.

---
 rtl/usb_phy_pkg.sv | 32 +++
 rtl/usb_tx_bitclk.sv | 39 +++
 rtl/usb_phy_tx.sv | 210 +++++++++++++++++++++
 tb/tb_usb_phy_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_phy_pkg.sv
// Shared encodings for the USB 1.1 FS/LS transmit PHY: FSM states, pad line
// levels, transceiver select code and the SYNC pattern.
package usb_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_e;

    // Pad levels as {dp, dn} in full-speed polarity.
    localparam logic [1:0] J_FS = 2'b10;
    localparam logic [1:0] K_FS = 2'b01;
    localparam logic [1:0] SE0  = 2'b00;

    localparam logic [1:0] XCVR_LS = 2'b10;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Low speed swaps J and K on the pads; SE0 is polarity independent.
    function automatic logic [1:0] pad_levels(input logic [1:0] line_fs, input logic ls);
        logic [1:0] pads;
        pads = line_fs;
        if (ls && (line_fs != SE0)) begin
            pads = {line_fs[0], line_fs[1]};
        end
        return pads;
    endfunction

endpackage

// File: rtl/usb_tx_bitclk.sv
// Bit-period strobe generator: restarts on load, then fires once every
// CLKS_PER_BIT_FS or CLKS_PER_BIT_LS cycles depending on the latched speed.
module usb_tx_bitclk #(
    parameter int CLKS_PER_BIT_FS = 4,
    parameter int CLKS_PER_BIT_LS = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic run,
    input  logic speed_ls,
    output logic strobe
);

    localparam int MAX_DIV = (CLKS_PER_BIT_LS > CLKS_PER_BIT_FS) ? CLKS_PER_BIT_LS : CLKS_PER_BIT_FS;
    localparam int CW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;

    localparam logic [CW-1:0] LAST_FS = CW'(CLKS_PER_BIT_FS - 1);
    localparam logic [CW-1:0] LAST_LS = CW'(CLKS_PER_BIT_LS - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last_cnt;

    assign last_cnt = speed_ls ? LAST_LS : LAST_FS;
    assign strobe   = run && (cnt == last_cnt);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load || !run || strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/usb_phy_tx.sv
// USB 1.1 FS/LS transmit PHY: UTMI byte handshake, SYNC, bit stuffing, NRZI, EOP.
// Optional keep-alive generation is built when USB_PHY_TX_KEEPALIVE_EN is defined.
module usb_phy_tx
    import usb_phy_pkg::*;
#(
    parameter int CLKS_PER_BIT_FS = 4,
    parameter int CLKS_PER_BIT_LS = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] utmi_data_i,
    input  logic       utmi_txvalid_i,
    output logic       utmi_txready_o,
    input  logic [1:0] utmi_xcvrselect_i,
`ifdef USB_PHY_TX_KEEPALIVE_EN
    input  logic       keepalive_i,
`endif
    output logic       usb_dp_o,
    output logic       usb_dn_o,
    output logic       usb_oe_o,
    output logic       tx_busy_o
);

    tx_state_e state_q, state_d;

    logic       speed_ls_q;
    logic [7:0] shift_q;
    logic [7:0] hold_q;
    logic [3:0] idx_q;      // bits of the current byte already launched (0..8)
    logic [2:0] ones_q;
    logic       last_q;
    logic       k_q;        // NRZI level: 0 = J, 1 = K
    logic       se0_q;
    logic       txready_q;

    logic       strobe;
    logic       start_pkt;
    logic       start_ka;
    logic       in_frame;
    logic       need_stuff;
    logic       byte_done;
    logic       do_stuff;
    logic       do_bit;
    logic       do_next_byte;
    logic       do_eop;
    logic       do_fetch;
    logic       send_data;
    logic       tx_bit;
    logic [1:0] line_fs;

    assign start_pkt = (state_q == IDLE) && utmi_txvalid_i;

`ifdef USB_PHY_TX_KEEPALIVE_EN
    assign start_ka = (state_q == IDLE) && !utmi_txvalid_i && keepalive_i
                      && (utmi_xcvrselect_i == XCVR_LS);
`else
    assign start_ka = 1'b0;
`endif

    usb_tx_bitclk #(
        .CLKS_PER_BIT_FS (CLKS_PER_BIT_FS),
        .CLKS_PER_BIT_LS (CLKS_PER_BIT_LS)
    ) u_bitclk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (start_pkt || start_ka),
        .run      (state_q != IDLE),
        .speed_ls (speed_ls_q),
        .strobe   (strobe)
    );

    // A pending stuff bit always wins over the next data bit or the EOP.
    assign in_frame     = (state_q == SYNC) || (state_q == DATA);
    assign need_stuff   = (ones_q == 3'd6);
    assign byte_done    = (idx_q == 4'd8);
    assign do_stuff     = in_frame && strobe && need_stuff;
    assign do_bit       = in_frame && strobe && !need_stuff && !byte_done;
    assign do_next_byte = in_frame && strobe && !need_stuff && byte_done && !last_q;
    assign do_eop       = in_frame && strobe && !need_stuff && byte_done && last_q;
    assign do_fetch     = do_bit && (idx_q == 4'd7);
    assign send_data    = do_bit || do_next_byte;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        tx_bit = 1'b0;
        if (do_bit) begin
            tx_bit = shift_q[idx_q[2:0]];
        end else if (do_next_byte) begin
            tx_bit = hold_q[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_pkt) begin
                    state_d = SYNC;
                end else if (start_ka) begin
                    state_d = EOP_SE0;
                end
            end
            SYNC: begin
                if (do_next_byte) begin
                    state_d = DATA;
                end else if (do_eop) begin
                    state_d = EOP_SE0;
                end
            end
            DATA: begin
                if (do_eop) begin
                    state_d = EOP_SE0;
                end
            end
            EOP_SE0: begin
                if (strobe && idx_q[0]) begin
                    state_d = EOP_J;
                end
            end
            EOP_J: begin
                if (strobe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        usb_oe_o       = (state_q != IDLE);
        tx_busy_o      = (state_q != IDLE);
        utmi_txready_o = txready_q;
        line_fs        = se0_q ? SE0 : (k_q ? K_FS : J_FS);
        {usb_dp_o, usb_dn_o} = pad_levels(line_fs, speed_ls_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            speed_ls_q <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            idx_q      <= '0;
            ones_q     <= '0;
            last_q     <= 1'b0;
            k_q        <= 1'b0;
            se0_q      <= 1'b0;
            txready_q  <= 1'b0;
        end else begin
            txready_q <= 1'b0;
            if (start_pkt) begin
                // SYNC bit 0 is launched on the start edge itself: a 0 from J gives K.
                speed_ls_q <= (utmi_xcvrselect_i == XCVR_LS);
                shift_q    <= SYNC_PATTERN;
                idx_q      <= 4'd1;
                ones_q     <= '0;
                last_q     <= 1'b0;
                k_q        <= 1'b1;
                se0_q      <= 1'b0;
            end else if (start_ka) begin
                speed_ls_q <= 1'b1;
                idx_q      <= '0;
                k_q        <= 1'b0;
                se0_q      <= 1'b1;
            end else if (do_stuff) begin
                k_q    <= ~k_q;
                ones_q <= '0;
            end else if (send_data) begin
                if (tx_bit) begin
                    ones_q <= ones_q + 3'd1;
                end else begin
                    ones_q <= '0;
                    k_q    <= ~k_q;
                end
                if (do_next_byte) begin
                    shift_q <= hold_q;
                    idx_q   <= 4'd1;
                end else begin
                    idx_q <= idx_q + 4'd1;
                end
                if (do_fetch) begin
                    if (utmi_txvalid_i) begin
                        hold_q    <= utmi_data_i;
                        txready_q <= 1'b1;
                    end else begin
                        last_q <= 1'b1;
                    end
                end
            end else if (do_eop) begin
                se0_q <= 1'b1;
                k_q   <= 1'b0;
                idx_q <= '0;
            end else if ((state_q == EOP_SE0) && strobe) begin
                idx_q <= 4'd1;
                if (idx_q[0]) begin
                    se0_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_phy_tx.sv
// Directed bench for usb_phy_tx: FS/LS packets, bit stuffing, EOP timing,
// mid-packet reset and (when USB_PHY_TX_KEEPALIVE_EN is defined) keep-alive.
module tb_usb_phy_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] utmi_data_i = 8'h00;
    logic       utmi_txvalid_i = 1'b0;
    logic       utmi_txready_o;
    logic [1:0] utmi_xcvrselect_i = 2'b00;
    logic       usb_dp_o;
    logic       usb_dn_o;
    logic       usb_oe_o;
    logic       tx_busy_o;
`ifdef USB_PHY_TX_KEEPALIVE_EN
    logic       keepalive_i = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] tx_bytes [4];
    logic [1:0] line_at [64];
    int         ready_at [4];
    int         n_ready;
    int         oe_cycles;
    int         se0_cycle;

    always #10 clk_i = ~clk_i;

    usb_phy_tx dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .utmi_data_i       (utmi_data_i),
        .utmi_txvalid_i    (utmi_txvalid_i),
        .utmi_txready_o    (utmi_txready_o),
        .utmi_xcvrselect_i (utmi_xcvrselect_i),
`ifdef USB_PHY_TX_KEEPALIVE_EN
        .keepalive_i       (keepalive_i),
`endif
        .usb_dp_o          (usb_dp_o),
        .usb_dn_o          (usb_dn_o),
        .usb_oe_o          (usb_oe_o),
        .tx_busy_o         (tx_busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic check_str(input string tag, input string observed, input string expected);
        n_total++;
        assert (observed == expected) n_pass++;
        else $error("FAIL %s: observed %s expected %s", tag, observed, expected);
    endtask

    // Decodes the sampled bit-time line levels into J/K/S characters.
    function automatic string sym_str(input int nbits, input bit ls);
        string s;
        string c;
        s = "";
        for (int k = 0; k < nbits; k++) begin
            case (line_at[k])
                2'b00:   c = "S";
                2'b10:   c = ls ? "K" : "J";
                2'b01:   c = ls ? "J" : "K";
                default: c = "X";
            endcase
            s = {s, c};
        end
        return s;
    endfunction

    // Raises txvalid with tx_bytes[0], acts as the SIE for nbytes bytes and
    // samples every bit time for a fixed budget of cycles.
    task automatic send_packet(input int nbytes, input bit ls, input int cycles);
        int div;
        int sent;
        div       = ls ? 32 : 4;
        sent      = 0;
        n_ready   = 0;
        oe_cycles = 0;
        se0_cycle = -1;
        for (int k = 0; k < 64; k++) line_at[k] = 2'b11;
        for (int k = 0; k < 4; k++) ready_at[k] = -1;
        utmi_xcvrselect_i = ls ? 2'b10 : 2'b00;
        utmi_data_i       = tx_bytes[0];
        utmi_txvalid_i    = 1'b1;
        for (int n = 1; n <= cycles; n++) begin
            tick();
            if (usb_oe_o) oe_cycles++;
            if (((n - 1) % div == 0) && ((n - 1) / div < 64)) line_at[(n - 1) / div] = {usb_dp_o, usb_dn_o};
            if (se0_cycle < 0 && usb_oe_o && !usb_dp_o && !usb_dn_o) se0_cycle = n;
            if (utmi_txready_o) begin
                if (n_ready < 4) ready_at[n_ready] = n;
                n_ready++;
                sent++;
                if (sent < nbytes) begin
                    utmi_data_i = tx_bytes[sent];
                end else begin
                    utmi_txvalid_i = 1'b0;
                    utmi_data_i    = 8'h00;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_oe", usb_oe_o, 1'b0);
        check("rst_txready", utmi_txready_o, 1'b0);
        check("rst_busy", tx_busy_o, 1'b0);
        check("rst_line", {usb_dp_o, usb_dn_o}, 2'b10);
        rst_i = 1'b0;
        tick();
        tick();
        check("idle_oe", usb_oe_o, 1'b0);

        // FS single byte 0xD2
        tx_bytes[0] = 8'hD2;
        send_packet(1, 1'b0, 90);
        check_str("fs_d2_line", sym_str(19, 1'b0), "KJKJKJKKJJKJJKKKSSJ");
        check("fs_d2_oe_cycles", oe_cycles, 76);
        check("fs_d2_nready", n_ready, 1);
        check("fs_d2_ready_cycle", ready_at[0], 29);
        check("fs_d2_done", tx_busy_o, 1'b0);
        tick();

        // FS 0xFF then 0x00: stuff bit after the fifth data one
        tx_bytes[0] = 8'hFF;
        tx_bytes[1] = 8'h00;
        send_packet(2, 1'b0, 125);
        check_str("fs_ff_line", sym_str(28, 1'b0), "KJKJKJKKKKKKKJJJJKJKJKJKJSSJ");
        check("fs_ff_nready", n_ready, 2);
        check("fs_ff_ready0", ready_at[0], 29);
        check("fs_ff_ready1", ready_at[1], 65);
        check("fs_ff_oe_cycles", oe_cycles, 112);
        check("fs_ff_done", tx_busy_o, 1'b0);
        tick();

        // LS three-byte packet A5 12 34
        tx_bytes[0] = 8'hA5;
        tx_bytes[1] = 8'h12;
        tx_bytes[2] = 8'h34;
        send_packet(3, 1'b1, 1200);
        check("ls_first_k_pads", line_at[0], 2'b10);
        check_str("ls_line", sym_str(35, 1'b1), "KJKJKJKKKJJKJJKKJJKJJKJKJKKJJJKJSSJ");
        check("ls_nready", n_ready, 3);
        check("ls_ready0", ready_at[0], 225);
        check("ls_ready1", ready_at[1], 481);
        check("ls_ready2", ready_at[2], 737);
        check("ls_oe_cycles", oe_cycles, 1120);
        check("ls_done", tx_busy_o, 1'b0);
        tick();

        // Trailing stuff bit: 0x3F then 0xFC
        tx_bytes[0] = 8'h3F;
        tx_bytes[1] = 8'hFC;
        send_packet(2, 1'b0, 130);
        check_str("trail_line", sym_str(29, 1'b0), "KJKJKJKKKKKKKJJKJKJJJJJJJKSSJ");
        check("trail_ready1", ready_at[1], 65);
        check("trail_se0_cycle", se0_cycle, 105);
        check("trail_oe_cycles", oe_cycles, 116);
        check("trail_done", tx_busy_o, 1'b0);
        tick();

        // Reset asserted during byte 2 while txready is high
        tx_bytes[0] = 8'h11;
        tx_bytes[1] = 8'h22;
        tx_bytes[2] = 8'h33;
        send_packet(3, 1'b0, 93);
        check("midrst_nready", n_ready, 3);
        check("midrst_ready_high", utmi_txready_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("midrst_oe", usb_oe_o, 1'b0);
        check("midrst_txready", utmi_txready_o, 1'b0);
        check("midrst_busy", tx_busy_o, 1'b0);
        utmi_txvalid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        tx_bytes[0] = 8'hD2;
        send_packet(1, 1'b0, 90);
        check_str("postrst_line", sym_str(19, 1'b0), "KJKJKJKKJJKJJKKKSSJ");
        check("postrst_ready_cycle", ready_at[0], 29);
        check("postrst_done", tx_busy_o, 1'b0);
        tick();

`ifdef USB_PHY_TX_KEEPALIVE_EN
        begin
            int ka_oe;
            int ka_se0;
            int ka_j;
            int ka_rdy;
            ka_oe  = 0;
            ka_se0 = 0;
            ka_j   = 0;
            ka_rdy = 0;
            utmi_xcvrselect_i = 2'b10;
            keepalive_i       = 1'b1;
            for (int n = 1; n <= 110; n++) begin
                tick();
                if (n == 1) keepalive_i = 1'b0;
                if (usb_oe_o) begin
                    ka_oe++;
                    if ({usb_dp_o, usb_dn_o} == 2'b00) ka_se0++;
                    if ({usb_dp_o, usb_dn_o} == 2'b01) ka_j++;
                end
                if (utmi_txready_o) ka_rdy++;
            end
            check("ka_ls_oe", ka_oe, 96);
            check("ka_ls_se0", ka_se0, 64);
            check("ka_ls_j", ka_j, 32);
            check("ka_ls_ready", ka_rdy, 0);

            ka_oe = 0;
            utmi_xcvrselect_i = 2'b00;
            keepalive_i       = 1'b1;
            for (int n = 1; n <= 40; n++) begin
                tick();
                if (n == 1) keepalive_i = 1'b0;
                if (usb_oe_o) ka_oe++;
            end
            check("ka_fs_ignored", ka_oe, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
